// File: rtl/id_ex_decode_if.sv
// rtl/id_ex_decode_if.sv - ID/EX register output bundle
//
// Carries the registered decode fields from the decode stage to EX and MEM.
// master: the decode stage, which drives every field.
// slave : the EX/MEM consumers, which only read the fields.
// Fields: ex_valid, ex_alu_opt, ex_imm, ex_src_a_pc, ex_src_b_imm, ex_rs1,
//         ex_rs2, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, ex_mem_size,
//         ex_branch, ex_jump, ex_pc, ex_illegal.
interface id_ex_decode_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [4:0]      ex_alu_opt;
    logic [XLEN-1:0] ex_imm;
    logic            ex_src_a_pc;
    logic            ex_src_b_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_reg_we;
    logic            ex_mem_re;
    logic            ex_mem_we;
    logic [2:0]      ex_mem_size;
    logic            ex_branch;
    logic            ex_jump;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;

    modport master (
        output ex_valid, ex_alu_opt, ex_imm, ex_src_a_pc, ex_src_b_imm,
               ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
               ex_mem_size, ex_branch, ex_jump, ex_pc, ex_illegal
    );

    modport slave (
        input  ex_valid, ex_alu_opt, ex_imm, ex_src_a_pc, ex_src_b_imm,
               ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
               ex_mem_size, ex_branch, ex_jump, ex_pc, ex_illegal
    );
endinterface

// File: rtl/id_ex_decode.sv
// rtl/id_ex_decode.sv - RV32I decode stage and ID/EX pipeline register
//
// Decodes the IF/ID instruction word into ALU op, operand selects, immediate
// and control bits, and registers them for one cycle. Detects load-use
// hazards and honours stall and flush.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   id_valid        IF/ID holds a real instruction
//   id_instr, id_pc instruction word and its pc
//   stall           hold the ID/EX register
//   flush           redirect: bubble the ID/EX register
//   load_use_stall  combinational: IF/ID must hold this cycle
//   ex              registered decode bundle (master side)
module id_ex_decode #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            load_use_stall,
    id_ex_decode_if.master  ex
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_JMP  = 5'd10;
    localparam logic [4:0] ALU_BEQ  = 5'd11;
    localparam logic [4:0] ALU_BNE  = 5'd12;
    localparam logic [4:0] ALU_BLT  = 5'd13;
    localparam logic [4:0] ALU_BGE  = 5'd14;
    localparam logic [4:0] ALU_BLTU = 5'd15;
    localparam logic [4:0] ALU_BGEU = 5'd16;
    localparam logic [4:0] ALU_PASB = 5'd17;

    typedef struct packed {
        logic            valid;
        logic [4:0]      alu_opt;
        logic [XLEN-1:0] imm;
        logic            src_a_pc;
        logic            src_b_imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic [2:0]      mem_size;
        logic            branch;
        logic            jump;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } ex_fields_t;

    ex_fields_t ex_q, ex_d, dec;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign funct7 = id_instr[31:25];

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                    id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_u = {id_instr[31:12], 12'b0};
    assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                    id_instr[20], id_instr[30:21], 1'b0};

    // OP and OP-IMM share one funct3 map; funct7 only selects the alternate
    // op for register forms, and for immediates only for the shift-right.
    logic       alt;
    logic [4:0] alu_rr;
    assign alt = (funct7 == F7_ALT) && ((opcode == OPC_OP) || (funct3 == 3'b101));

    always_comb begin
        alu_rr = ALU_ADD;
        case (funct3)
            3'b000:  alu_rr = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_rr = ALU_SLL;
            3'b010:  alu_rr = ALU_SLT;
            3'b011:  alu_rr = ALU_SLTU;
            3'b100:  alu_rr = ALU_XOR;
            3'b101:  alu_rr = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_rr = ALU_OR;
            default: alu_rr = ALU_AND;
        endcase
    end

    logic illegal;

    always_comb begin
        dec     = '0;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.rd  = rd;
        dec.pc  = id_pc;
        imm32   = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alu_opt = alu_rr;
                dec.reg_we  = 1'b1;
                illegal     = !((funct7 == F7_BASE) ||
                                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec.alu_opt   = alu_rr;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                imm32         = imm_i;
                illegal       = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                                ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OPC_LOAD: begin
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                dec.mem_re    = 1'b1;
                dec.mem_size  = funct3;
                imm32         = imm_i;
                illegal       = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.src_b_imm = 1'b1;
                dec.mem_we    = 1'b1;
                dec.mem_size  = funct3;
                imm32         = imm_s;
                illegal       = funct3[2] || (funct3 == 3'b011);
            end
            OPC_LUI: begin
                dec.alu_opt   = ALU_PASB;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                imm32         = imm_u;
            end
            OPC_AUIPC: begin
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                imm32         = imm_u;
            end
            OPC_JAL: begin
                dec.alu_opt   = ALU_JMP;
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_we    = 1'b1;
                imm32         = imm_j;
            end
            OPC_JALR: begin
                dec.alu_opt   = ALU_JMP;
                dec.src_b_imm = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_we    = 1'b1;
                imm32         = imm_i;
                illegal       = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                imm32      = imm_b;
                case (funct3)
                    3'b000:  dec.alu_opt = ALU_BEQ;
                    3'b001:  dec.alu_opt = ALU_BNE;
                    3'b100:  dec.alu_opt = ALU_BLT;
                    3'b101:  dec.alu_opt = ALU_BGE;
                    3'b110:  dec.alu_opt = ALU_BLTU;
                    3'b111:  dec.alu_opt = ALU_BGEU;
                    default: illegal     = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        dec.imm = XLEN'(imm32);

        // An illegal word keeps only its raw register fields and pc.
        if (illegal) begin
            dec.alu_opt   = ALU_ADD;
            dec.imm       = '0;
            dec.src_a_pc  = 1'b0;
            dec.src_b_imm = 1'b0;
            dec.reg_we    = 1'b0;
            dec.mem_re    = 1'b0;
            dec.mem_we    = 1'b0;
            dec.mem_size  = '0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
        dec.illegal = illegal & id_valid;

        // Control bits only matter for a real instruction; x0 is never written.
        dec.valid  = id_valid;
        dec.reg_we = dec.reg_we & id_valid & (rd != 5'd0);
        dec.mem_re = dec.mem_re & id_valid;
        dec.mem_we = dec.mem_we & id_valid;
        dec.branch = dec.branch & id_valid;
        dec.jump   = dec.jump & id_valid;
    end

    // Hazard against the load now in EX. A bubble word has rs1 = x0 so it
    // never needs to wait; it is excluded explicitly to keep that obvious.
    logic uses_rs2;
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign load_use_stall = !rst && !flush && id_valid && (id_instr != NOP_INSTR) &&
                            ex_q.valid && ex_q.mem_re && (ex_q.rd != 5'd0) &&
                            ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2)));

    // Flush beats stall; stall beats the load-use bubble so the hazard is
    // simply re-evaluated once the stall releases.
    always_comb begin
        ex_d = dec;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex.ex_valid     = ex_q.valid;
    assign ex.ex_alu_opt   = ex_q.alu_opt;
    assign ex.ex_imm       = ex_q.imm;
    assign ex.ex_src_a_pc  = ex_q.src_a_pc;
    assign ex.ex_src_b_imm = ex_q.src_b_imm;
    assign ex.ex_rs1       = ex_q.rs1;
    assign ex.ex_rs2       = ex_q.rs2;
    assign ex.ex_rd        = ex_q.rd;
    assign ex.ex_reg_we    = ex_q.reg_we;
    assign ex.ex_mem_re    = ex_q.mem_re;
    assign ex.ex_mem_we    = ex_q.mem_we;
    assign ex.ex_mem_size  = ex_q.mem_size;
    assign ex.ex_branch    = ex_q.branch;
    assign ex.ex_jump      = ex_q.jump;
    assign ex.ex_pc        = ex_q.pc;
    assign ex.ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_ex_decode.sv
// tb/tb_id_ex_decode.sv - self-checking bench for id_ex_decode
module tb_id_ex_decode;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        stall;
    logic        flush;
    logic        load_use_stall;

    id_ex_decode_if #(.XLEN(32)) exi ();

    id_ex_decode #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .stall          (stall),
        .flush          (flush),
        .load_use_stall (load_use_stall),
        .ex             (exi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  alu_opt;
        logic [31:0] imm;
        logic        src_a_pc;
        logic        src_b_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jump;
        logic [31:0] pc;
        logic        illegal;
    } ex_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [7:0]  flags; // {a_pc, b_imm, reg_we, mem_re, mem_we, branch, jump, illegal}
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    ex_t  exp_q;
    logic seen_lus;
    vec_t vecs[16];

    // ALU code by {alternate-funct7, funct3}; -1 marks an illegal combination.
    int op_tbl[16] = '{0, 5, 6, 7, 4, 8, 3, 2, 1, -1, -1, -1, -1, 9, -1, -1};
    int br_tbl[8]  = '{11, 12, -1, -1, 13, 14, 15, 16};

    localparam logic [31:0] ADD_X1    = 32'h003100B3; // add x1,x2,x3
    localparam logic [31:0] SUB_X5    = 32'h407302B3; // sub x5,x6,x7
    localparam logic [31:0] LW_X3     = 32'h0000A183; // lw  x3,0(x1)
    localparam logic [31:0] LW_X0     = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] ADD_X4_X3 = 32'h00518233; // add x4,x3,x5

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic ex_t get_act();
        ex_t a;
        a.valid     = exi.ex_valid;
        a.alu_opt   = exi.ex_alu_opt;
        a.imm       = exi.ex_imm;
        a.src_a_pc  = exi.ex_src_a_pc;
        a.src_b_imm = exi.ex_src_b_imm;
        a.rs1       = exi.ex_rs1;
        a.rs2       = exi.ex_rs2;
        a.rd        = exi.ex_rd;
        a.reg_we    = exi.ex_reg_we;
        a.mem_re    = exi.ex_mem_re;
        a.mem_we    = exi.ex_mem_we;
        a.mem_size  = exi.ex_mem_size;
        a.branch    = exi.ex_branch;
        a.jump      = exi.ex_jump;
        a.pc        = exi.ex_pc;
        a.illegal   = exi.ex_illegal;
        return a;
    endfunction

    function automatic logic [45:0] sel(input ex_t e);
        return {e.valid, e.alu_opt, e.imm, e.src_a_pc, e.src_b_imm, e.reg_we,
                e.mem_re, e.mem_we, e.branch, e.jump, e.illegal};
    endfunction

    function automatic bit uses_rs2(input logic [31:0] ins);
        return (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    endfunction

    // Reference decoder: immediates by signed-integer arithmetic, ALU codes
    // by table lookup.
    function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        ex_t e;
        int  si, f3, f7, alu, imm, alt;
        bit  ill, a_pc, b_imm, we, re, wr, br, jp;
        int  size;
        si = int'(ins);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        alu = 0; imm = 0; ill = 0; size = 0;
        a_pc = 0; b_imm = 0; we = 0; re = 0; wr = 0; br = 0; jp = 0;
        case (ins[6:0])
            7'h33: begin
                alt = (f7 == 32) ? 1 : 0;
                alu = op_tbl[alt*8 + f3];
                ill = !(f7 == 0 || f7 == 32) || (alu < 0);
                we  = 1;
            end
            7'h13: begin
                alt = (f3 == 5 && f7 == 32) ? 1 : 0;
                alu = op_tbl[alt*8 + f3];
                ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
                imm = si >>> 20; b_imm = 1; we = 1;
            end
            7'h03: begin
                ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                imm = si >>> 20; b_imm = 1; we = 1; re = 1; size = f3;
            end
            7'h23: begin
                ill = (f3 > 2);
                imm = ((si >>> 25) <<< 5) | int'(ins[11:7]);
                b_imm = 1; wr = 1; size = f3;
            end
            7'h37: begin alu = 17; imm = si & 32'hFFFFF000; b_imm = 1; we = 1; end
            7'h17: begin imm = si & 32'hFFFFF000; a_pc = 1; b_imm = 1; we = 1; end
            7'h6F: begin
                alu = 10; a_pc = 1; b_imm = 1; jp = 1; we = 1;
                imm = ((si >>> 31) <<< 20) | (int'(ins[19:12]) << 12) |
                      (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
            end
            7'h67: begin
                alu = 10; b_imm = 1; jp = 1; we = 1; imm = si >>> 20; ill = (f3 != 0);
            end
            7'h63: begin
                alu = br_tbl[f3]; ill = (alu < 0); br = 1;
                imm = ((si >>> 31) <<< 12) | (int'(ins[7]) << 11) |
                      (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
            end
            default: ill = 1;
        endcase
        if (ill) begin
            alu = 0; imm = 0; size = 0;
            a_pc = 0; b_imm = 0; we = 0; re = 0; wr = 0; br = 0; jp = 0;
        end
        if (ins[11:7] == 5'd0) we = 0;
        e.valid     = v;
        e.alu_opt   = alu[4:0];
        e.imm       = imm;
        e.src_a_pc  = a_pc;
        e.src_b_imm = b_imm;
        e.rs1       = ins[19:15];
        e.rs2       = ins[24:20];
        e.rd        = ins[11:7];
        e.reg_we    = we & v;
        e.mem_re    = re & v;
        e.mem_we    = wr & v;
        e.mem_size  = size[2:0];
        e.branch    = br & v;
        e.jump      = jp & v;
        e.pc        = pc;
        e.illegal   = ill & v;
        return e;
    endfunction

    // One clock: drive, check the hazard output, clock, check the EX bundle.
    task automatic cycle(input bit r, input bit v, input logic [31:0] ins,
                         input logic [31:0] pc, input bit st, input bit fl, input string tag);
        bit hz;
        rst = r; id_valid = v; id_instr = ins; id_pc = pc; stall = st; flush = fl;
        #1;
        hz = !r && !fl && v && exp_q.valid && exp_q.mem_re && (exp_q.rd != 0) &&
             ((exp_q.rd == ins[19:15]) || (uses_rs2(ins) && (exp_q.rd == ins[24:20])));
        seen_lus = load_use_stall;
        chk({tag, " load_use_stall"}, load_use_stall, hz);
        if (r || fl)   exp_q = '0;
        else if (st)   exp_q = exp_q;
        else if (hz)   exp_q = '0;
        else           exp_q = model_decode(ins, pc, v);
        @(posedge clk);
        #1;
        chk({tag, " ex bundle"}, get_act(), exp_q);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2, 3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h37;
            6: w[6:0] = 7'h17;
            7: w[6:0] = 7'h6F;
            8: w[6:0] = 7'h67;
            9: w[6:0] = 7'h63;
            default: w[6:0] = 7'($urandom);
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 15) == 0) w = 32'h0000_0013;
        return w;
    endfunction

    initial begin
        ex_t held;

        vecs[0]  = '{"add",      32'h003100B3, 5'd0,  32'h00000000, 8'h20};
        vecs[1]  = '{"add_x0",   32'h00310033, 5'd0,  32'h00000000, 8'h00};
        vecs[2]  = '{"sub",      32'h407302B3, 5'd1,  32'h00000000, 8'h20};
        vecs[3]  = '{"srai",     32'h4030D093, 5'd9,  32'h00000403, 8'h60};
        vecs[4]  = '{"andi",     32'hFFF0F093, 5'd2,  32'hFFFFFFFF, 8'h60};
        vecs[5]  = '{"lui",      32'h12345137, 5'd17, 32'h12345000, 8'h60};
        vecs[6]  = '{"bgeu",     32'hFE20FCE3, 5'd16, 32'hFFFFFFF8, 8'h04};
        vecs[7]  = '{"jal",      32'h010000EF, 5'd10, 32'h00000010, 8'hE2};
        vecs[8]  = '{"jalr",     32'hFFC100E7, 5'd10, 32'hFFFFFFFC, 8'h62};
        vecs[9]  = '{"lw",       32'h0000A183, 5'd0,  32'h00000000, 8'h70};
        vecs[10] = '{"sw",       32'h0020A423, 5'd0,  32'h00000008, 8'h48};
        vecs[11] = '{"auipc",    32'h00001297, 5'd0,  32'h00001000, 8'hE0};
        vecs[12] = '{"nop",      32'h00000013, 5'd0,  32'h00000000, 8'h40};
        vecs[13] = '{"ill_opc",  32'h0000007F, 5'd0,  32'h00000000, 8'h01};
        vecs[14] = '{"ill_mul",  32'h023100B3, 5'd0,  32'h00000000, 8'h01};
        vecs[15] = '{"ill_slli", 32'h40309093, 5'd0,  32'h00000000, 8'h01};

        exp_q = '0;

        // Reset with a valid add sitting in ID.
        cycle(1, 1, ADD_X1, 32'h100, 0, 0, "rst1");
        chk("reset ex cleared", get_act(), 96'h0);
        chk("reset lus", seen_lus, 1'b0);
        cycle(1, 1, ADD_X1, 32'h100, 0, 0, "rst2");
        chk("reset ex cleared 2", get_act(), 96'h0);
        cycle(0, 1, ADD_X1, 32'h100, 0, 0, "post_rst");
        chk("post_rst add", {exi.ex_valid, exi.ex_alu_opt, exi.ex_rd, exi.ex_reg_we},
            {1'b1, 5'd0, 5'd1, 1'b1});

        // Decode table, each vector separated by an idle slot.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, vecs[i].instr, 32'h1000 + 32'(i*4), 0, 0, vecs[i].name);
            chk({vecs[i].name, " decode"}, sel(get_act()),
                {1'b1, vecs[i].alu, vecs[i].imm, vecs[i].flags});
            cycle(0, 0, 32'h0000_0013, 32'h0, 0, 0, "idle");
        end

        // Load-use: one bubble, then the consumer enters.
        cycle(0, 1, LW_X3, 32'h200, 0, 0, "lu_lw");
        cycle(0, 1, ADD_X4_X3, 32'h204, 0, 0, "lu_hit");
        chk("lu asserted", seen_lus, 1'b1);
        chk("lu bubble", exi.ex_valid, 1'b0);
        cycle(0, 1, ADD_X4_X3, 32'h204, 0, 0, "lu_retry");
        chk("lu released", seen_lus, 1'b0);
        chk("lu consumer", {exi.ex_valid, exi.ex_rs1, exi.ex_rd}, {1'b1, 5'd3, 5'd4});
        cycle(0, 1, LW_X0, 32'h208, 0, 0, "lu_lw_x0");
        cycle(0, 1, ADD_X4_X3, 32'h20C, 0, 0, "lu_x0");
        chk("lu x0 no stall", seen_lus, 1'b0);
        chk("lu x0 enters", exi.ex_valid, 1'b1);

        // Flush wins over stall.
        cycle(0, 1, ADD_X1, 32'h300, 1, 1, "flush_stall");
        chk("flush bubble", {exi.ex_valid, exi.ex_reg_we}, 2'b00);

        // Stall hold for three cycles with a changing ID word.
        cycle(0, 1, LW_X3, 32'h400, 0, 0, "hold_load");
        held = model_decode(LW_X3, 32'h400, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, rand_instr(), 32'h404 + 32'(i*4), 1, 0, "hold");
            chk("hold stable", get_act(), held);
        end
        cycle(0, 1, SUB_X5, 32'h410, 0, 0, "hold_release");
        chk("hold resume", {exi.ex_valid, exi.ex_alu_opt}, {1'b1, 5'd1});

        // Stall together with load-use: hold, then bubble, then consumer.
        cycle(0, 1, LW_X3, 32'h500, 0, 0, "st_lu_lw");
        cycle(0, 1, ADD_X4_X3, 32'h504, 1, 0, "st_lu");
        chk("st_lu asserted", seen_lus, 1'b1);
        chk("st_lu holds load", {exi.ex_mem_re, exi.ex_rd}, {1'b1, 5'd3});
        cycle(0, 1, ADD_X4_X3, 32'h504, 0, 0, "st_lu2");
        chk("st_lu2 asserted", seen_lus, 1'b1);
        chk("st_lu2 bubble", exi.ex_valid, 1'b0);
        cycle(0, 1, ADD_X4_X3, 32'h504, 0, 0, "st_lu3");
        chk("st_lu3 consumer", {seen_lus, exi.ex_valid, exi.ex_rs1}, {1'b0, 1'b1, 5'd3});

        // Reset in the middle of a stall forgets the pending hazard.
        cycle(0, 1, LW_X3, 32'h600, 0, 0, "rms_lw");
        cycle(0, 1, ADD_X4_X3, 32'h604, 1, 0, "rms_stall");
        cycle(1, 1, ADD_X4_X3, 32'h604, 1, 0, "rms_rst");
        chk("rms cleared", get_act(), 96'h0);
        cycle(0, 1, ADD_X4_X3, 32'h604, 0, 0, "rms_after");
        chk("rms no stall", {seen_lus, exi.ex_valid}, {1'b0, 1'b1});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85), rand_instr(),
                  $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 8), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
